// File: rtl/beam_search_ctrl_if.sv
// Expand-request and neighbour-stream handshake between beam_search_ctrl and the fetch/distance datapath.
// master = search controller side, slave = graph_fetch/distance datapath side.
interface beam_search_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DIST_W = 32
);
  logic              exp_req_valid_out;
  logic              exp_req_ready_in;
  logic [ADDR_W-1:0] exp_req_addr_out;
  logic              nb_valid_in;
  logic              nb_ready_out;
  logic [ADDR_W-1:0] nb_addr_in;
  logic [DIST_W-1:0] nb_dist_in;
  logic              nb_last_in;

  modport master (
    output exp_req_valid_out, exp_req_addr_out, nb_ready_out,
    input  exp_req_ready_in, nb_valid_in, nb_addr_in, nb_dist_in, nb_last_in
  );

  modport slave (
    input  exp_req_valid_out, exp_req_addr_out, nb_ready_out,
    output exp_req_ready_in, nb_valid_in, nb_addr_in, nb_dist_in, nb_last_in
  );
endinterface

// File: rtl/beam_search_ctrl.sv
// Beam search controller: keeps a distance-sorted beam of L candidates, expands the closest
// unchecked one through the external fetch/distance pipeline and presents the best k results.
module beam_search_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DIST_W = 32,
  parameter int L      = 8,
  parameter int ITER_W = 16,
  localparam int KW    = $clog2(L) + 1
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 start_in,
  input  logic                 abort_in,
  input  logic [ADDR_W-1:0]    entry_addr_in,
  input  logic [DIST_W-1:0]    entry_dist_in,
  input  logic [KW-1:0]        k_in,
  input  logic [ITER_W-1:0]    max_iter_in,
  beam_search_ctrl_if.master   bus,
  output logic [ADDR_W-1:0]    topk_addr_out [L],
  output logic [DIST_W-1:0]    topk_dist_out [L],
  output logic [KW-1:0]        topk_count_out,
  output logic                 valid_out,
  output logic                 busy_out,
  output logic [ITER_W-1:0]    iter_out,
  output logic [2:0]           state_out
);

  localparam int IW = $clog2(L);
  localparam logic [KW-1:0]     LK   = KW'(L);
  localparam logic [ITER_W-1:0] IMAX = '1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_FETCH  = 3'd2,
    S_EXPAND = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q [L];
  logic [ADDR_W-1:0]   addr_d [L];
  logic [DIST_W-1:0]   dist_q [L];
  logic [DIST_W-1:0]   dist_d [L];
  logic [L-1:0]        chk_q, chk_d;
  logic [KW-1:0]       count_q, count_d;
  logic [ADDR_W-1:0]   sel_addr_q, sel_addr_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [KW-1:0]       k_q, k_d;
  logic [ITER_W-1:0]   maxit_q, maxit_d;
  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   taddr_q [L];
  logic [ADDR_W-1:0]   taddr_d [L];
  logic [DIST_W-1:0]   tdist_q [L];
  logic [DIST_W-1:0]   tdist_d [L];
  logic [KW-1:0]       tcount_q, tcount_d;

  logic                found;
  logic [IW-1:0]       sel_idx;
  logic                dup;
  logic [KW-1:0]       ins_pos;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    dist_d     = dist_q;
    chk_d      = chk_q;
    count_d    = count_q;
    sel_addr_d = sel_addr_q;
    iter_d     = iter_q;
    k_d        = k_q;
    maxit_d    = maxit_q;
    valid_d    = valid_q;
    taddr_d    = taddr_q;
    tdist_d    = tdist_q;
    tcount_d   = tcount_q;
    found      = 1'b0;
    sel_idx    = '0;
    dup        = 1'b0;
    ins_pos    = count_q;
    bus.exp_req_valid_out = 1'b0;
    bus.nb_ready_out      = 1'b0;

    // Downward scans so the lowest matching index wins; ins_pos defaults to the tail.
    for (int i = L - 1; i >= 0; i--) begin
      if (KW'(i) < count_q) begin
        if (!chk_q[i]) begin
          found   = 1'b1;
          sel_idx = IW'(i);
        end
        if (addr_q[i] == bus.nb_addr_in) dup = 1'b1;
        if (dist_q[i] > bus.nb_dist_in) ins_pos = KW'(i);
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_in) begin
          for (int i = 0; i < L; i++) begin
            addr_d[i] = '0;
            dist_d[i] = '0;
          end
          chk_d     = '0;
          addr_d[0] = entry_addr_in;
          dist_d[0] = entry_dist_in;
          count_d   = KW'(1);
          iter_d    = '0;
          k_d       = (k_in > LK) ? LK : k_in;
          maxit_d   = max_iter_in;
          valid_d   = 1'b0;
          state_d   = S_SELECT;
        end
      end
      S_SELECT: begin
        if (abort_in) begin
          state_d = S_IDLE;
        end else if (!found || (maxit_q != '0 && iter_q == maxit_q)) begin
          state_d  = S_DONE;
          valid_d  = 1'b1;
          tcount_d = (k_q < count_q) ? k_q : count_q;
          for (int i = 0; i < L; i++) begin
            taddr_d[i] = (KW'(i) < tcount_d) ? addr_q[i] : '0;
            tdist_d[i] = (KW'(i) < tcount_d) ? dist_q[i] : '0;
          end
        end else begin
          sel_addr_d = addr_q[sel_idx];
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        bus.exp_req_valid_out = 1'b1;
        if (abort_in) begin
          state_d = S_IDLE;
        end else if (bus.exp_req_ready_in) begin
          for (int i = 0; i < L; i++) begin
            if (KW'(i) < count_q && addr_q[i] == sel_addr_q) chk_d[i] = 1'b1;
          end
          iter_d  = (iter_q == IMAX) ? iter_q : iter_q + ITER_W'(1);
          state_d = S_EXPAND;
        end
      end
      S_EXPAND: begin
        bus.nb_ready_out = 1'b1;
        if (abort_in) begin
          state_d = S_IDLE;
        end else begin
          // Stable insert: ties land after existing equals; a full beam evicts its tail.
          if (bus.nb_valid_in && !dup &&
              !(count_q == LK && bus.nb_dist_in >= dist_q[L-1])) begin
            for (int i = 1; i < L; i++) begin
              if (KW'(i) > ins_pos) begin
                addr_d[i] = addr_q[i-1];
                dist_d[i] = dist_q[i-1];
                chk_d[i]  = chk_q[i-1];
              end
            end
            for (int i = 0; i < L; i++) begin
              if (KW'(i) == ins_pos) begin
                addr_d[i] = bus.nb_addr_in;
                dist_d[i] = bus.nb_dist_in;
                chk_d[i]  = 1'b0;
              end
            end
            count_d = (count_q == LK) ? count_q : count_q + KW'(1);
          end
          if (bus.nb_last_in) state_d = S_SELECT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= S_IDLE;
      chk_q      <= '0;
      count_q    <= '0;
      sel_addr_q <= '0;
      iter_q     <= '0;
      k_q        <= '0;
      maxit_q    <= '0;
      valid_q    <= 1'b0;
      tcount_q   <= '0;
      for (int i = 0; i < L; i++) begin
        addr_q[i]  <= '0;
        dist_q[i]  <= '0;
        taddr_q[i] <= '0;
        tdist_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      chk_q      <= chk_d;
      count_q    <= count_d;
      sel_addr_q <= sel_addr_d;
      iter_q     <= iter_d;
      k_q        <= k_d;
      maxit_q    <= maxit_d;
      valid_q    <= valid_d;
      tcount_q   <= tcount_d;
      for (int i = 0; i < L; i++) begin
        addr_q[i]  <= addr_d[i];
        dist_q[i]  <= dist_d[i];
        taddr_q[i] <= taddr_d[i];
        tdist_q[i] <= tdist_d[i];
      end
    end
  end

  assign bus.exp_req_addr_out = sel_addr_q;
  assign topk_addr_out        = taddr_q;
  assign topk_dist_out        = tdist_q;
  assign topk_count_out       = tcount_q;
  assign valid_out            = valid_q;
  assign busy_out             = (state_q == S_SELECT) || (state_q == S_FETCH) || (state_q == S_EXPAND);
  assign iter_out             = iter_q;
  assign state_out            = state_q;

endmodule

// File: tb/tb_beam_search_ctrl.sv
// Directed testbench for beam_search_ctrl: the bench plays the fetch/distance datapath
// and checks every observation against hand-computed beam contents.
module tb_beam_search_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int L  = 8;
  localparam int IW = 16;
  localparam int KW = $clog2(L) + 1;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] entryAddr = '0;
  logic [DW-1:0] entryDist = '0;
  logic [KW-1:0] kVal = '0;
  logic [IW-1:0] maxIter = '0;
  logic [AW-1:0] topkAddr [L];
  logic [DW-1:0] topkDist [L];
  logic [KW-1:0] topkCount;
  logic          validOut;
  logic          busyOut;
  logic [IW-1:0] iterOut;
  logic [2:0]    stateOut;

  int vecCount  = 0;
  int missCount = 0;

  beam_search_ctrl_if #(.ADDR_W(AW), .DIST_W(DW)) bus ();

  beam_search_ctrl #(.ADDR_W(AW), .DIST_W(DW), .L(L), .ITER_W(IW)) dut (
    .clk_in         (clk),
    .rst_n_in       (rstN),
    .start_in       (start),
    .abort_in       (abort),
    .entry_addr_in  (entryAddr),
    .entry_dist_in  (entryDist),
    .k_in           (kVal),
    .max_iter_in    (maxIter),
    .bus            (bus),
    .topk_addr_out  (topkAddr),
    .topk_dist_out  (topkDist),
    .topk_count_out (topkCount),
    .valid_out      (validOut),
    .busy_out       (busyOut),
    .iter_out       (iterOut),
    .state_out      (stateOut)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecCount++;
    assert (obs === exp)
    else begin
      missCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bounded wait: a timeout shows up as a state miscompare.
  task automatic waitState(input logic [2:0] target, input string tag);
    int n;
    n = 0;
    while (stateOut !== target && n < 50) begin
      step();
      n++;
    end
    checkOutput(tag, 64'(stateOut), 64'(target));
  endtask

  task automatic doStart(input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [KW-1:0] k, input logic [IW-1:0] m);
    entryAddr = a;
    entryDist = d;
    kVal      = k;
    maxIter   = m;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic expectFetch(input logic [AW-1:0] a, input string tag);
    waitState(3'd2, {tag, "_wait"});
    checkOutput({tag, "_addr"}, 64'(bus.exp_req_addr_out), 64'(a));
    bus.exp_req_ready_in = 1'b1;
    step();
    bus.exp_req_ready_in = 1'b0;
  endtask

  task automatic applyStimulus(input logic v, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic l);
    bus.nb_valid_in = v;
    bus.nb_addr_in  = a;
    bus.nb_dist_in  = d;
    bus.nb_last_in  = l;
    step();
    bus.nb_valid_in = 1'b0;
    bus.nb_last_in  = 1'b0;
  endtask

  initial begin
    bus.exp_req_ready_in = 1'b0;
    bus.nb_valid_in      = 1'b0;
    bus.nb_addr_in       = '0;
    bus.nb_dist_in       = '0;
    bus.nb_last_in       = 1'b0;

    #3;
    checkOutput("rst_state", 64'(stateOut), 64'd0);
    checkOutput("rst_valid", 64'(validOut), 64'd0);
    checkOutput("rst_busy", 64'(busyOut), 64'd0);
    checkOutput("rst_expvalid", 64'(bus.exp_req_valid_out), 64'd0);
    checkOutput("rst_nbready", 64'(bus.nb_ready_out), 64'd0);
    checkOutput("rst_topkcount", 64'(topkCount), 64'd0);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    step();

    // Basic search: seed 5/100, k=3, unlimited iterations.
    $display("[TB] basic search");
    doStart(32'd5, 32'd100, 4'd3, 16'd0);
    checkOutput("b_busy", 64'(busyOut), 64'd1);
    expectFetch(32'd5, "b_f0");
    checkOutput("b_nbready", 64'(bus.nb_ready_out), 64'd1);
    applyStimulus(1'b1, 32'd7, 32'd40, 1'b0);
    applyStimulus(1'b1, 32'd9, 32'd60, 1'b0);
    applyStimulus(1'b1, 32'd3, 32'd80, 1'b1);
    expectFetch(32'd7, "b_f1");
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
    expectFetch(32'd9, "b_f2");
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
    expectFetch(32'd3, "b_f3");
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
    waitState(3'd4, "b_done");
    checkOutput("b_valid", 64'(validOut), 64'd1);
    checkOutput("b_busy_done", 64'(busyOut), 64'd0);
    checkOutput("b_iter", 64'(iterOut), 64'd4);
    checkOutput("b_count", 64'(topkCount), 64'd3);
    checkOutput("b_a0", 64'(topkAddr[0]), 64'd7);
    checkOutput("b_d0", 64'(topkDist[0]), 64'd40);
    checkOutput("b_a1", 64'(topkAddr[1]), 64'd9);
    checkOutput("b_d1", 64'(topkDist[1]), 64'd60);
    checkOutput("b_a2", 64'(topkAddr[2]), 64'd3);
    checkOutput("b_d2", 64'(topkDist[2]), 64'd80);
    checkOutput("b_a3", 64'(topkAddr[3]), 64'd0);

    // Full beam: k clamped 15->8, tail-equal drop, mid insert with eviction.
    $display("[TB] full beam");
    doStart(32'd100, 32'd10, 4'd15, 16'd1);
    expectFetch(32'd100, "f_f0");
    for (int i = 1; i < 8; i++) applyStimulus(1'b1, 32'(100 + i), 32'(10 + 10 * i), 1'b0);
    applyStimulus(1'b1, 32'd108, 32'd80, 1'b0);
    applyStimulus(1'b1, 32'd109, 32'd35, 1'b1);
    waitState(3'd4, "f_done");
    checkOutput("f_count", 64'(topkCount), 64'd8);
    checkOutput("f_iter", 64'(iterOut), 64'd1);
    checkOutput("f_a2", 64'(topkAddr[2]), 64'd102);
    checkOutput("f_a3", 64'(topkAddr[3]), 64'd109);
    checkOutput("f_d3", 64'(topkDist[3]), 64'd35);
    checkOutput("f_a4", 64'(topkAddr[4]), 64'd103);
    checkOutput("f_a7", 64'(topkAddr[7]), 64'd106);
    checkOutput("f_d7", 64'(topkDist[7]), 64'd70);

    // Duplicates: resident seed and a repeated neighbour are both dropped.
    $display("[TB] duplicates");
    doStart(32'd9, 32'd50, 4'd4, 16'd1);
    expectFetch(32'd9, "d_f0");
    applyStimulus(1'b1, 32'd4, 32'd20, 1'b0);
    applyStimulus(1'b1, 32'd9, 32'd1, 1'b0);
    applyStimulus(1'b1, 32'd4, 32'd5, 1'b1);
    waitState(3'd4, "d_done");
    checkOutput("d_count", 64'(topkCount), 64'd2);
    checkOutput("d_a0", 64'(topkAddr[0]), 64'd4);
    checkOutput("d_d0", 64'(topkDist[0]), 64'd20);
    checkOutput("d_a1", 64'(topkAddr[1]), 64'd9);
    checkOutput("d_d1", 64'(topkDist[1]), 64'd50);
    checkOutput("d_a2", 64'(topkAddr[2]), 64'd0);

    // Iteration cap of 2 leaves unchecked entries in the results.
    $display("[TB] iteration cap");
    doStart(32'd1, 32'd50, 4'd8, 16'd2);
    expectFetch(32'd1, "m_f0");
    applyStimulus(1'b1, 32'd2, 32'd10, 1'b0);
    applyStimulus(1'b1, 32'd3, 32'd20, 1'b1);
    expectFetch(32'd2, "m_f1");
    applyStimulus(1'b1, 32'd4, 32'd30, 1'b0);
    applyStimulus(1'b1, 32'd5, 32'd40, 1'b1);
    waitState(3'd4, "m_done");
    checkOutput("m_valid", 64'(validOut), 64'd1);
    checkOutput("m_iter", 64'(iterOut), 64'd2);
    checkOutput("m_count", 64'(topkCount), 64'd5);
    checkOutput("m_a2", 64'(topkAddr[2]), 64'd4);
    checkOutput("m_d4", 64'(topkDist[4]), 64'd50);
    checkOutput("m_a5", 64'(topkAddr[5]), 64'd0);

    // Stalled request then abort.
    $display("[TB] stall and abort");
    doStart(32'd20, 32'd10, 4'd2, 16'd0);
    checkOutput("s_valid_cleared", 64'(validOut), 64'd0);
    checkOutput("s_topk_held", 64'(topkCount), 64'd5);
    waitState(3'd2, "s_wait");
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("s_expvalid", 64'(bus.exp_req_valid_out), 64'd1);
      checkOutput("s_addr", 64'(bus.exp_req_addr_out), 64'd20);
      checkOutput("s_iter", 64'(iterOut), 64'd0);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checkOutput("s_state", 64'(stateOut), 64'd0);
    checkOutput("s_valid", 64'(validOut), 64'd0);
    checkOutput("s_busy", 64'(busyOut), 64'd0);
    checkOutput("s_expvalid_off", 64'(bus.exp_req_valid_out), 64'd0);

    // Asynchronous reset in the middle of EXPAND, then a fresh search.
    $display("[TB] async reset");
    doStart(32'd30, 32'd10, 4'd2, 16'd0);
    expectFetch(32'd30, "r_f0");
    applyStimulus(1'b1, 32'd31, 32'd5, 1'b0);
    checkOutput("r_expand", 64'(stateOut), 64'd3);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("r_state", 64'(stateOut), 64'd0);
    checkOutput("r_iter", 64'(iterOut), 64'd0);
    checkOutput("r_busy", 64'(busyOut), 64'd0);
    checkOutput("r_nbready", 64'(bus.nb_ready_out), 64'd0);
    checkOutput("r_topkcount", 64'(topkCount), 64'd0);
    checkOutput("r_topka0", 64'(topkAddr[0]), 64'd0);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    step();
    doStart(32'd40, 32'd70, 4'd2, 16'd0);
    expectFetch(32'd40, "r_f1");
    applyStimulus(1'b1, 32'd41, 32'd60, 1'b1);
    expectFetch(32'd41, "r_f2");
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
    waitState(3'd4, "r_done");
    checkOutput("r_iter2", 64'(iterOut), 64'd2);
    checkOutput("r_count", 64'(topkCount), 64'd2);
    checkOutput("r_a0", 64'(topkAddr[0]), 64'd41);
    checkOutput("r_d1", 64'(topkDist[1]), 64'd70);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
